// File: rtl/range_reader_pkg.sv
// -----------------------------------------------------------------------------
// range_reader_pkg
// Shared definitions for the range_reader block:
//   rr_state_e  - 4-bit encoding of the burst sequencer states
//   DIR_UP      - i_dir value for an ascending (+1) walk
//   DIR_DOWN    - i_dir value for a descending (-1) walk
//   RD_CNT_W    - width of the read-latency counter (READ_DELAY is at most 31)
// -----------------------------------------------------------------------------
package range_reader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD    = 4'd1,
    ST_WAIT_RD = 4'd2,
    ST_PRESENT = 4'd3,
    ST_ACK_HI  = 4'd4,
    ST_ACK_LO  = 4'd5,
    ST_DONE    = 4'd6
  } rr_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int RD_CNT_W = 5;

endpackage : range_reader_pkg

// File: rtl/range_addr_gen.sv
// -----------------------------------------------------------------------------
// range_addr_gen
// Holds the burst range and walk direction captured at burst start, produces
// the memory read address one word at a time and flags the last address.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   capture             sample addr_begin/addr_end/dir (burst start)
//   advance             produce the next address (first word loads begin)
//   addr_begin/addr_end inclusive burst range
//   dir                 DIR_UP (+1) or DIR_DOWN (-1), wraps modulo 2^ADDR_W
//   addra               current read address
//   is_last             addra equals the captured end address
// -----------------------------------------------------------------------------
module range_addr_gen
  import range_reader_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic              advance,
  input  logic [ADDR_W-1:0] addr_begin,
  input  logic [ADDR_W-1:0] addr_end,
  input  logic              dir,
  output logic [ADDR_W-1:0] addra,
  output logic              is_last
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] begin_r;
  logic [ADDR_W-1:0] end_r;
  logic              dir_r;
  logic              first_r;
  logic [ADDR_W-1:0] step_addr_s;

  // Burst range, direction and first-word flag captured for the whole burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      begin_r <= '0;
      end_r   <= '0;
      dir_r   <= DIR_UP;
      first_r <= 1'b1;
    end else if (capture) begin
      begin_r <= addr_begin;
      end_r   <= addr_end;
      dir_r   <= dir;
      first_r <= 1'b1;
    end else if (advance) begin
      first_r <= 1'b0;
    end else begin
      first_r <= first_r;
    end
  end

  // Next address in the walk direction; natural unsigned overflow gives the wrap
  always_comb begin
    step_addr_s = addra;
    if (dir_r == DIR_DOWN) begin
      step_addr_s = addra - ADDR_ONE;
    end else begin
      step_addr_s = addra + ADDR_ONE;
    end
  end

  // Read address register: begin on the first word, stepped afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addra <= '0;
    end else if (advance) begin
      addra <= first_r ? begin_r : step_addr_s;
    end else begin
      addra <= addra;
    end
  end

  assign is_last = (addra == end_r);

endmodule : range_addr_gen

// File: rtl/range_reader.sv
// -----------------------------------------------------------------------------
// range_reader
// Reads an inclusive address range from a fixed-latency memory and hands the
// words downstream one at a time with a four-phase valid/acknowledge handshake.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   im_start                 upstream burst request (level, sampled in IDLE)
//   im_work                  downstream per-word acknowledge (level)
//   om_start                 burst active toward downstream
//   om_work                  word valid on om_data
//   om_data                  delivered word, held until the next word
//   addra / douta            memory read address / read data
//   addra_begin, addra_end   inclusive burst range
//   i_dir                    0 = ascending, 1 = descending
//   om_count                 words acknowledged in the current/last burst
//                            (present only when RANGE_READER_CNT_EN is defined)
// Parameters: ADDR_W, DATA_W, READ_DELAY (memory latency, 1..31 cycles).
// -----------------------------------------------------------------------------
module range_reader
  import range_reader_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int READ_DELAY = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              im_start,
  input  logic              im_work,
  output logic              om_start,
  output logic              om_work,
  output logic [DATA_W-1:0] om_data,
  output logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] douta,
  input  logic [ADDR_W-1:0] addra_begin,
  input  logic [ADDR_W-1:0] addra_end,
  input  logic              i_dir
`ifdef RANGE_READER_CNT_EN
  ,
  output logic [ADDR_W:0]   om_count
`endif
);

  // Counter reaches READ_DELAY-1 on the cycle that hands over to PRESENT,
  // which places om_work at edge READ_DELAY+3 of the burst.
  localparam logic [RD_CNT_W-1:0] RD_LAST = RD_CNT_W'(READ_DELAY - 1);
  localparam logic [RD_CNT_W-1:0] RD_ONE  = RD_CNT_W'(1);

  rr_state_e             state_r;
  rr_state_e             state_s;
  logic [RD_CNT_W-1:0]   rd_cnt_r;
  logic [RD_CNT_W-1:0]   rd_cnt_s;
  logic                  om_start_s;
  logic                  om_work_s;
  logic [DATA_W-1:0]     om_data_s;
  logic                  capture_s;
  logic                  advance_s;
  logic                  is_last_s;

  assign capture_s = (state_r == ST_IDLE) && im_start;
  assign advance_s = (state_r == ST_LOAD);

  range_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture    (capture_s),
    .advance    (advance_s),
    .addr_begin (addra_begin),
    .addr_end   (addra_end),
    .dir        (i_dir),
    .addra      (addra),
    .is_last    (is_last_s)
  );

  // State, latency counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      rd_cnt_r <= '0;
      om_start <= 1'b0;
      om_work  <= 1'b0;
      om_data  <= '0;
    end else begin
      state_r  <= state_s;
      rd_cnt_r <= rd_cnt_s;
      om_start <= om_start_s;
      om_work  <= om_work_s;
      om_data  <= om_data_s;
    end
  end

  // Next-state and next-output decode; everything holds unless changed below
  always_comb begin
    state_s    = state_r;
    rd_cnt_s   = rd_cnt_r;
    om_start_s = om_start;
    om_work_s  = om_work;
    om_data_s  = om_data;
    case (state_r)
      ST_IDLE: begin
        if (im_start) begin
          state_s    = ST_LOAD;
          om_start_s = 1'b1;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_LOAD: begin
        rd_cnt_s = '0;
        state_s  = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (rd_cnt_r == RD_LAST) begin
          state_s  = ST_PRESENT;
        end else begin
          rd_cnt_s = rd_cnt_r + RD_ONE;
        end
      end
      ST_PRESENT: begin
        om_data_s = douta;
        om_work_s = 1'b1;
        state_s   = ST_ACK_HI;
      end
      ST_ACK_HI: begin
        // An acknowledge already high on entry is taken on this first cycle
        if (im_work) begin
          om_work_s = 1'b0;
          state_s   = ST_ACK_LO;
        end else begin
          state_s   = ST_ACK_HI;
        end
      end
      ST_ACK_LO: begin
        if (!im_work) begin
          if (is_last_s) begin
            om_start_s = 1'b0;
            state_s    = ST_DONE;
          end else begin
            state_s    = ST_LOAD;
          end
        end else begin
          state_s = ST_ACK_LO;
        end
      end
      ST_DONE: begin
        if (!im_start) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        rd_cnt_s   = '0;
        om_start_s = 1'b0;
        om_work_s  = 1'b0;
      end
    endcase
  end

`ifdef RANGE_READER_CNT_EN
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  // Acknowledged-word count: cleared at burst start, held after completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      om_count <= '0;
    end else if (capture_s) begin
      om_count <= '0;
    end else if ((state_r == ST_ACK_HI) && im_work) begin
      om_count <= om_count + CNT_ONE;
    end else begin
      om_count <= om_count;
    end
  end
`endif

endmodule : range_reader

// File: tb/tb_range_reader.sv
// -----------------------------------------------------------------------------
// tb_range_reader
// Scoreboard bench for range_reader: each burst pushes its expected
// (address, word) sequence; each delivered word is popped and compared.
// A READ_DELAY-deep pipelined memory model drives douta.
// Define RANGE_READER_CNT_EN to also check om_count.
// -----------------------------------------------------------------------------
module tb_range_reader;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int RD = 5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          im_start;
  logic          im_work;
  logic          om_start;
  logic          om_work;
  logic [DW-1:0] om_data;
  logic [AW-1:0] addra;
  logic [DW-1:0] douta;
  logic [AW-1:0] addra_begin;
  logic [AW-1:0] addra_end;
  logic          i_dir;
`ifdef RANGE_READER_CNT_EN
  logic [AW:0]   om_count;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  logic [DW-1:0] rd_pipe [RD];

  always #5 clk = ~clk;

  range_reader #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .READ_DELAY (RD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .im_start    (im_start),
    .im_work     (im_work),
    .om_start    (om_start),
    .om_work     (om_work),
    .om_data     (om_data),
    .addra       (addra),
    .douta       (douta),
    .addra_begin (addra_begin),
    .addra_end   (addra_end),
    .i_dir       (i_dir)
`ifdef RANGE_READER_CNT_EN
    ,
    .om_count    (om_count)
`endif
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] p;
    logic [AW-1:0] s;
    p = a * 12'd37;
    s = a >> 5;
    return p[DW-1:0] + s[DW-1:0] + 8'd11;
  endfunction

  // Memory model with READ_DELAY cycles of latency
  always @(posedge clk) begin
    rd_pipe[0] <= mem_word(addra);
    for (int i = 1; i < RD; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign douta = rd_pipe[RD-1];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_work(input logic lvl, input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < budget) begin
      step();
      cycles++;
      if (om_work === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_burst(input logic [AW-1:0] b, input logic [AW-1:0] e, input logic d,
                            output int n);
    logic [AW-1:0] diff;
    logic [AW-1:0] a;
    diff = d ? (b - e) : (e - b);
    n    = int'(diff) + 1;
    a    = b;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back({a, mem_word(a)});
      a = d ? (a - 12'd1) : (a + 12'd1);
    end
  endtask

  task automatic serve_word(input int stall, input bit pre, input bit chk_lat);
    exp_t          ex;
    int            cyc;
    bit            ok;
    int            bad;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    if (pre) im_work = 1'b1;
    wait_work(1'b1, 200, cyc, ok);
    check_eq("word_seen", 32'(ok), 32'd1);
    if (!ok) return;
    if (chk_lat) check_eq("work_latency", 32'(cyc), 32'(RD + 3));
    check_eq("om_start_active", 32'(om_start), 32'd1);
    check_eq("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      ex = sb_q.pop_front();
      check_eq("addra", 32'(addra), 32'(ex.addr));
      check_eq("om_data", 32'(om_data), 32'(ex.data));
    end
    a0  = addra;
    d0  = om_data;
    bad = 0;
    for (int i = 0; i < stall; i++) begin
      step();
      if (om_work !== 1'b1 || addra !== a0 || om_data !== d0) bad++;
    end
    if (stall > 0) check_eq("stall_stable", 32'(bad), 32'd0);
    im_work = 1'b1;
    wait_work(1'b0, 20, cyc, ok);
    check_eq("ack_fall", 32'(ok), 32'd1);
    check_eq("ack_latency", 32'(cyc), 32'd1);
    if (stall > 0) begin
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        step();
        if (om_work !== 1'b0 || addra !== a0 || om_data !== d0) bad++;
      end
      check_eq("ack_hold_no_load", 32'(bad), 32'd0);
    end
    im_work = 1'b0;
    if (pre) step();  // let ACK_LO observe the release before re-asserting
  endtask

  task automatic run_burst(input logic [AW-1:0] b, input logic [AW-1:0] e, input logic d,
                           input int stall, input bit drop, input bit pre);
    int n;
    int bad;
    addra_begin = b;
    addra_end   = e;
    i_dir       = d;
    push_burst(b, e, d, n);
    im_start = 1'b1;
    for (int w = 0; w < n; w++) begin
      serve_word(stall, pre, (w == 0) || !pre);
      if (w == 0) begin
        // range inputs must be held internally for the rest of the burst
        addra_begin = ~b;
        addra_end   = ~e;
        i_dir       = ~d;
        if (drop) im_start = 1'b0;
      end
    end
    if (!pre) step();
    check_eq("start_fall", 32'(om_start), 32'd0);
`ifdef RANGE_READER_CNT_EN
    check_eq("om_count", 32'(om_count), 32'(n));
`endif
    if (im_start) begin
      bad = 0;
      for (int i = 0; i < 3; i++) begin
        step();
        if (om_start !== 1'b0 || om_work !== 1'b0) bad++;
      end
      check_eq("done_hold", 32'(bad), 32'd0);
      im_start = 1'b0;
    end
    step();
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    logic [AW-1:0] rb;
    logic [AW-1:0] rl;
    logic          rdir;
    rst_n       = 1'b0;
    im_start    = 1'b0;
    im_work     = 1'b0;
    addra_begin = '0;
    addra_end   = '0;
    i_dir       = 1'b0;
    repeat (3) step();
    check_eq("rst_om_start", 32'(om_start), 32'd0);
    check_eq("rst_om_work", 32'(om_work), 32'd0);
    check_eq("rst_om_data", 32'(om_data), 32'd0);
    check_eq("rst_addra", 32'(addra), 32'd0);
    rst_n = 1'b1;
    repeat (RD + 2) step();

    // ascending 10..13, reactive acknowledge
    run_burst(12'd10, 12'd13, 1'b0, 0, 1'b0, 1'b0);
    // descending across zero: 2,1,0,4095,4094,4093; acknowledge pre-asserted
    run_burst(12'd2, 12'd4093, 1'b1, 0, 1'b0, 1'b1);
    // single word
    run_burst(12'd100, 12'd100, 1'b0, 0, 1'b0, 1'b0);
    // ascending across the top with im_start dropped after the first word
    run_burst(12'd4094, 12'd1, 1'b0, 0, 1'b1, 1'b0);
    // downstream stalls for 20 cycles on every word
    run_burst(12'd52, 12'd50, 1'b1, 20, 1'b0, 1'b0);

    // reset during the third word's read wait
    addra_begin = 12'd20;
    addra_end   = 12'd24;
    i_dir       = 1'b0;
    push_burst(12'd20, 12'd24, 1'b0, n);
    im_start = 1'b1;
    serve_word(0, 1'b0, 1'b1);
    serve_word(0, 1'b0, 1'b1);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check_eq("arst_om_start", 32'(om_start), 32'd0);
    check_eq("arst_om_work", 32'(om_work), 32'd0);
    check_eq("arst_om_data", 32'(om_data), 32'd0);
    check_eq("arst_addra", 32'(addra), 32'd0);
`ifdef RANGE_READER_CNT_EN
    check_eq("arst_om_count", 32'(om_count), 32'd0);
`endif
    sb_q.delete();
    im_start = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (RD + 2) step();
    check_eq("post_rst_idle", 32'(om_start), 32'd0);
    run_burst(12'd20, 12'd24, 1'b0, 0, 1'b0, 1'b0);

    // a few random short bursts
    for (int k = 0; k < 4; k++) begin
      rb   = 12'($urandom_range(0, 4095));
      rl   = 12'($urandom_range(0, 3));
      rdir = 1'($urandom_range(0, 1));
      run_burst(rb, rdir ? (rb - rl) : (rb + rl), rdir, 0, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_range_reader
